muldiv_unit: RTL and testbench

Iterative RV64M multiply/divide execution unit. Sits directly downstream of the register file: consumes rs1/rs2 read data together with the destination index, and after a multi-cycle computation produces a one-cycle write-back (`done`, `rd_out`, `result`) that drives the regfile's `reg_write`/`rd`/`rd_din` path. Decode holds issue while `busy` is high.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_sign_fix.sv | 15 +
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV64M multiply/divide unit.
//   op_e     - RV M-extension funct3 encodings
//   state_e  - unit sequencing states (IDLE / RUN / DONE)
//   is_div() - funct3 selects a divide-type operation (DIV/DIVU/REM/REMU)
//   is_rem() - funct3 selects a remainder operation (REM/REMU)
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue / write-back bundle between decode+regfile and muldiv_unit.
//   start, flush, op, rs1_data, rs2_data, rd_in : issuer -> unit
//   busy, done, rd_out, result                  : unit -> issuer / regfile write port
// Modports: master (issuer side), slave (execution unit side).
interface muldiv_if #(
  parameter int W = 64
);
  logic         start;
  logic         flush;
  logic [2:0]   op;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic [4:0]   rd_in;
  logic         busy;
  logic         done;
  logic [4:0]   rd_out;
  logic [W-1:0] result;

  modport master (
    output start, flush, op, rs1_data, rs2_data, rd_in,
    input  busy, done, rd_out, result
  );

  modport slave (
    input  start, flush, op, rs1_data, rs2_data, rd_in,
    output busy, done, rd_out, result
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational conditional two's-complement negation.
// Used both to take absolute values of operands and to restore the sign
// of the final product / quotient / remainder.
//   val_i [N] : input value
//   neg_i     : 1 = negate, 0 = pass through
//   val_o [N] : result
module muldiv_sign_fix #(
  parameter int N = 64
) (
  input  logic [N-1:0] val_i,
  input  logic         neg_i,
  output logic [N-1:0] val_o
);
  assign val_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide execution unit.
// One shift-add (multiply) or restoring-divide step per cycle over W cycles,
// then a single-cycle write-back pulse (done/rd_out/result).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : muldiv_if.slave (start/flush/op/rs1_data/rs2_data/rd_in in,
//           busy/done/rd_out/result out)
// Build option: MULDIV_SIGNED_EN enables signed MULH/MULHSU/DIV/REM and the
// signed-overflow fast path; without it those encodings run unsigned.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int REG_WIDTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int W  = REG_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] RUN  = 2'(ST_RUN);
  localparam logic [1:0] DONE = 2'(ST_DONE);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   opb_q, opb_d;      // multiplicand or divisor (magnitude)
  logic [2*W-1:0] acc_q, acc_d;      // {product hi | remainder, product lo | quotient}
  logic [4:0]     rd_q, rd_d;        // destination held while in RUN
  logic [4:0]     rd_out_q, rd_out_d;
  logic [W-1:0]   result_q, result_d;

  logic           accept, fast, ovf;
  logic [W-1:0]   abs_a, abs_b, fast_res, res_sel;
  logic [W:0]     mul_sum, div_shift;
  logic [W-1:0]   div_diff;
  logic           div_ge;
  logic [2*W-1:0] acc_step, fin_raw, fin_fix;

  assign accept = (state_q != RUN) && bus.start && !bus.flush;

  // One iteration. Multiply: add multiplicand into the upper half when the
  // current multiplier bit (acc LSB) is set, then shift right. Divide: shift
  // the next dividend bit into the partial remainder and subtract if it fits.
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  // The difference is below 2^W whenever it is used, so W bits suffice.
  assign div_diff  = div_shift[W-1:0] - opb_q;
  assign acc_step  = is_div(op_q)
                   ? {(div_ge ? div_diff : div_shift[W-1:0]), acc_q[W-2:0], div_ge}
                   : {mul_sum, acc_q[W-1:1]};

  // Divide results are zero-extended so one 2W-bit negation serves all ops.
  assign fin_raw = is_div(op_q)
                 ? {{W{1'b0}}, (is_rem(op_q) ? acc_step[2*W-1:W] : acc_step[W-1:0])}
                 : acc_step;
  assign res_sel = (op_q == OP_MUL || is_div(op_q)) ? fin_fix[W-1:0] : fin_fix[2*W-1:W];

`ifdef MULDIV_SIGNED_EN
  logic sgn_a, sgn_b, neg_in;
  logic neg_q, neg_d;

  assign sgn_a  = bus.rs1_data[W-1] &&
                  (bus.op == OP_MULH || bus.op == OP_MULHSU || bus.op == OP_DIV || bus.op == OP_REM);
  assign sgn_b  = bus.rs2_data[W-1] &&
                  (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM);
  // Remainder follows the dividend; product and quotient follow sign XOR.
  assign neg_in = is_rem(bus.op) ? sgn_a : (sgn_a ^ sgn_b);
  assign ovf    = (bus.op == OP_DIV || bus.op == OP_REM) &&
                  (bus.rs1_data == {1'b1, {(W-1){1'b0}}}) && (&bus.rs2_data);

  muldiv_sign_fix #(.N(W))   u_abs_a (.val_i(bus.rs1_data), .neg_i(sgn_a), .val_o(abs_a));
  muldiv_sign_fix #(.N(W))   u_abs_b (.val_i(bus.rs2_data), .neg_i(sgn_b), .val_o(abs_b));
  muldiv_sign_fix #(.N(2*W)) u_res   (.val_i(fin_raw),      .neg_i(neg_q), .val_o(fin_fix));

  assign neg_d = accept ? neg_in : neg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) neg_q <= 1'b0;
    else       neg_q <= neg_d;
  end
`else
  assign abs_a   = bus.rs1_data;
  assign abs_b   = bus.rs2_data;
  assign ovf     = 1'b0;
  assign fin_fix = fin_raw;
`endif

  // Zero divisor / signed overflow bypass the iteration entirely.
  assign fast     = is_div(bus.op) && ((bus.rs2_data == '0) || ovf);
  assign fast_res = ovf ? (is_rem(bus.op) ? '0 : bus.rs1_data)
                        : (is_rem(bus.op) ? bus.rs1_data : '1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    case (state_q)
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = res_sel;
            rd_out_d = rd_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin  // IDLE or DONE: both accept a new operation
        state_d = IDLE;
        if (accept) begin
          if (fast) begin
            state_d  = DONE;
            result_d = fast_res;
            rd_out_d = bus.rd_in;
          end else begin
            state_d = RUN;
            cnt_d   = CW'(W - 1);
            op_d    = bus.op;
            opb_d   = abs_b;
            acc_d   = {{W{1'b0}}, abs_a};
            rd_d    = bus.rd_in;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.rd_out = rd_out_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors, hand-written multi-cycle sequences
// (back-to-back, ignored start, flush, mid-run reset) and randomized ops
// compared against an arithmetic reference model. Honours MULDIV_SIGNED_EN.
module tb_muldiv_unit;
  localparam int W = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  muldiv_if #(.W(W)) bus ();

  muldiv_unit #(.REG_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    else n_pass++;
  endtask

  // Reference: plain wide arithmetic on the RISC-V M rules.
  function automatic logic [63:0] model(input logic [2:0] op_in, input logic [63:0] a, input logic [63:0] b);
    logic [2:0]         op;
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    logic [63:0]        m;
    op = op_in;
`ifndef MULDIV_SIGNED_EN
    if (op == 3'd1 || op == 3'd2) op = 3'd3;
    else if (op == 3'd4) op = 3'd5;
    else if (op == 3'd6) op = 3'd7;
`endif
    sa = a;
    sb = b;
    m  = '0;
    case (op)
      3'd0: begin p = {64'd0, a} * {64'd0, b}; m = p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; m = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; m = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; m = p[127:64]; end
      3'd4: m = (b == 0) ? ONES : (a == MINV && b == ONES) ? a : 64'(sa / sb);
      3'd5: m = (b == 0) ? ONES : a / b;
      3'd6: m = (b == 0) ? a : (a == MINV && b == ONES) ? 64'd0 : 64'(sa % sb);
      default: m = (b == 0) ? a : a % b;
    endcase
    return m;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (!op[2]) return W + 1;
    if (b == 0) return 1;
`ifdef MULDIV_SIGNED_EN
    if (!op[0] && a == MINV && b == ONES) return 1;
`endif
    return W + 1;
  endfunction

  // Drive an issue so that start is sampled at the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Count cycles (sampled on falling edges) until done or the budget expires.
  task automatic collect(input int budget, input int drop_at, input int flush_at,
                         output logic seen, output logic [63:0] res, output logic [4:0] rd,
                         output int lat, output int busy_n);
    seen = 1'b0; res = '0; rd = '0; lat = 0; busy_n = 0;
    while (!seen && lat < budget) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        res  = bus.result;
        rd   = bus.rd_out;
      end
      if (lat == drop_at) bus.start = 1'b0;
      bus.flush = (lat == flush_at);
    end
  endtask

  task automatic finish_vec(input string tag, input vec_t v, input logic seen, input logic [63:0] res,
                            input logic [4:0] rd, input int lat, input int busy_n);
    $display("txn %s op=%0d a=0x%h b=0x%h rd=%0d -> result=0x%h rd_out=%0d lat=%0d busy=%0d",
             tag, v.op, v.a, v.b, v.rd, res, rd, lat, busy_n);
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check({tag, ".result"}, res, v.exp);
    check({tag, ".rd_out"}, 64'(rd), 64'(v.rd));
    check({tag, ".latency"}, 64'(lat), 64'(v.lat));
    check({tag, ".busy_cycles"}, 64'(busy_n), (v.lat == 1) ? 64'd0 : 64'(W));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic seen; logic [63:0] res; logic [4:0] rd; int lat; int busy_n;
    issue(v.op, v.a, v.b, v.rd);
    collect(200, 0, 0, seen, res, rd, lat, busy_n);
    finish_vec(tag, v, seen, res, rd, lat, busy_n);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic seen; logic [63:0] res; logic [4:0] rd; int lat; int busy_n;

    vecs.push_back('{op:3'd0, a:64'd7,  b:64'd6, rd:5'd5,  exp:64'd42,  lat:65});
    vecs.push_back('{op:3'd3, a:ONES,   b:64'd2, rd:5'd1,  exp:64'd1,   lat:65});
    vecs.push_back('{op:3'd5, a:64'd100, b:64'd7, rd:5'd2, exp:64'd14,  lat:65});
    vecs.push_back('{op:3'd7, a:64'd100, b:64'd7, rd:5'd3, exp:64'd2,   lat:65});
    vecs.push_back('{op:3'd5, a:64'd5,  b:64'd0, rd:5'd4,  exp:ONES,    lat:1});
    vecs.push_back('{op:3'd7, a:64'd5,  b:64'd0, rd:5'd31, exp:64'd5,   lat:1});
    vecs.push_back('{op:3'd0, a:64'd3,  b:64'd5, rd:5'd0,  exp:64'd15,  lat:65});
    vecs.push_back('{op:3'd0, a:ONES,   b:ONES,  rd:5'd8,  exp:64'd1,   lat:65});
    vecs.push_back('{op:3'd5, a:ONES,   b:64'd1, rd:5'd9,  exp:ONES,    lat:65});
`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{op:3'd4, a:64'hFFFF_FFFF_FFFF_FFF9, b:64'd2, rd:5'd10, exp:64'hFFFF_FFFF_FFFF_FFFD, lat:65});
    vecs.push_back('{op:3'd6, a:64'hFFFF_FFFF_FFFF_FFF9, b:64'd2, rd:5'd11, exp:ONES, lat:65});
    vecs.push_back('{op:3'd4, a:MINV, b:ONES, rd:5'd12, exp:MINV, lat:1});
    vecs.push_back('{op:3'd6, a:MINV, b:ONES, rd:5'd13, exp:64'd0, lat:1});
    vecs.push_back('{op:3'd1, a:ONES, b:ONES, rd:5'd14, exp:64'd0, lat:65});
    vecs.push_back('{op:3'd2, a:ONES, b:ONES, rd:5'd15, exp:ONES, lat:65});
`else
    vecs.push_back('{op:3'd4, a:64'hFFFF_FFFF_FFFF_FFF9, b:64'd2, rd:5'd10, exp:64'h7FFF_FFFF_FFFF_FFFC, lat:65});
    vecs.push_back('{op:3'd1, a:ONES, b:ONES, rd:5'd14, exp:64'hFFFF_FFFF_FFFF_FFFE, lat:65});
    vecs.push_back('{op:3'd6, a:64'd100, b:64'd0, rd:5'd13, exp:64'd100, lat:1});
`endif

    reset = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
    repeat (2) @(negedge clk);
    check("reset.busy",   64'(bus.busy),   64'd0);
    check("reset.done",   64'(bus.done),   64'd0);
    check("reset.rd_out", 64'(bus.rd_out), 64'd0);
    check("reset.result", bus.result,      64'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Back-to-back: second op issued in the DONE cycle of the first.
    issue(3'd3, ONES, 64'd2, 5'd6);
    collect(200, 0, 0, seen, res, rd, lat, busy_n);
    finish_vec("b2b_a", '{op:3'd3, a:ONES, b:64'd2, rd:5'd6, exp:64'd1, lat:65}, seen, res, rd, lat, busy_n);
    issue(3'd5, 64'd100, 64'd7, 5'd7);
    collect(200, 0, 0, seen, res, rd, lat, busy_n);
    finish_vec("b2b_b", '{op:3'd5, a:64'd100, b:64'd7, rd:5'd7, exp:64'd14, lat:65}, seen, res, rd, lat, busy_n);
    issue(3'd7, 64'd100, 64'd7, 5'd8);
    collect(200, 0, 0, seen, res, rd, lat, busy_n);
    finish_vec("b2b_c", '{op:3'd7, a:64'd100, b:64'd7, rd:5'd8, exp:64'd2, lat:65}, seen, res, rd, lat, busy_n);
    @(negedge clk);

    // A start held during RUN must not disturb the operation in flight.
    issue(3'd0, 64'd7, 64'd6, 5'd5);
    bus.start = 1'b1; bus.op = 3'd5; bus.rs1_data = 64'd100; bus.rs2_data = 64'd7; bus.rd_in = 5'd3;
    collect(200, 3, 0, seen, res, rd, lat, busy_n);
    finish_vec("ignore_start", '{op:3'd0, a:64'd7, b:64'd6, rd:5'd5, exp:64'd42, lat:65}, seen, res, rd, lat, busy_n);
    @(negedge clk);

    // Reset mid-RUN clears everything immediately; next op runs normally.
    issue(3'd0, 64'd3, 64'd4, 5'd7);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset.busy",   64'(bus.busy),   64'd0);
    check("midreset.done",   64'(bus.done),   64'd0);
    check("midreset.rd_out", 64'(bus.rd_out), 64'd0);
    check("midreset.result", bus.result,      64'd0);
    $display("txn midreset busy=%0d done=%0d rd_out=%0d result=0x%h", bus.busy, bus.done, bus.rd_out, bus.result);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_vec("after_reset", '{op:3'd0, a:64'd7, b:64'd6, rd:5'd5, exp:64'd42, lat:65});
    @(negedge clk);

    // Flush at RUN cycle 10: no write-back, previous result (42, rd 5) holds.
    issue(3'd0, 64'd3, 64'd3, 5'd9);
    collect(80, 0, 10, seen, res, rd, lat, busy_n);
    $display("txn flush done_seen=%0d busy=%0d result=0x%h rd_out=%0d", seen, busy_n, bus.result, bus.rd_out);
    check("flush.no_done",     64'(seen),       64'd0);
    check("flush.busy_cycles", 64'(busy_n),     64'd10);
    check("flush.busy_now",    64'(bus.busy),   64'd0);
    check("flush.result_hold", bus.result,      64'd42);
    check("flush.rd_hold",     64'(bus.rd_out), 64'd5);
    @(negedge clk);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      v.op = 3'($urandom_range(0, 7));
      v.a  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: v.b = 64'd0;
        1: v.b = 64'($urandom_range(1, 1000));
        2: begin v.a = MINV; v.b = ONES; end
        3: v.b = {{32{1'b1}}, $urandom};
        default: v.b = {$urandom, $urandom};
      endcase
      v.rd  = 5'($urandom_range(0, 31));
      v.exp = model(v.op, v.a, v.b);
      v.lat = model_lat(v.op, v.a, v.b);
      run_vec($sformatf("rand%0d", i), v);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
